// File: rtl/button_event.sv
// button_event: turns a debounced level into press/release/long/repeat events.
// Ports: clock, reset (sync, active-high), level_in, event_valid/event_ready/event_code, event_overflow, pressed.
// Optional BUTTON_EVENT_FIFO_EN: 4-entry FWFT event FIFO instead of a single output register.
module button_event #(
   parameter longint CLOCK_HZ              = 12_000_000,
   parameter longint TICK_HZ               = 1000,
   parameter int     LONG_PRESS_TICKS      = 500,
   parameter int     REPEAT_DELAY_TICKS    = 250,
   parameter int     REPEAT_INTERVAL_TICKS = 100
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       level_in,
   output logic       event_valid,
   input  logic       event_ready,
   output logic [2:0] event_code,
   output logic       event_overflow,
   output logic       pressed
);

   localparam longint DIVIDER = CLOCK_HZ / TICK_HZ;
   localparam int DIV_W  = $clog2(DIVIDER);
   localparam int MAX_AB = (LONG_PRESS_TICKS > REPEAT_DELAY_TICKS) ?
                           LONG_PRESS_TICKS : REPEAT_DELAY_TICKS;
   localparam int MAX_T  = (MAX_AB > REPEAT_INTERVAL_TICKS) ?
                           MAX_AB : REPEAT_INTERVAL_TICKS;
   localparam int CNT_W  = $clog2(MAX_T + 1);

   localparam logic [2:0] EV_PRESS     = 3'd0;
   localparam logic [2:0] EV_REL_SHORT = 3'd1;
   localparam logic [2:0] EV_LONG      = 3'd2;
   localparam logic [2:0] EV_REPEAT    = 3'd3;
   localparam logic [2:0] EV_REL_LONG  = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESSED,
      S_HELD,
      S_REPEATING
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [DIV_W-1:0] div_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_inc;
   logic             level_q;
   logic             tick;
   logic             rise;
   logic             fall;
   logic             long_hit;
   logic             delay_hit;
   logic             intv_hit;
   logic             ev_new;
   logic [2:0]       ev_code;

   // Free-running divider; never re-phased by button activity.
   always_ff @(posedge clock) begin
      if (reset) begin
         div_q   <= '0;
         level_q <= 1'b0;
      end else begin
         div_q   <= (div_q == DIV_W'(DIVIDER - 1)) ? '0 : div_q + DIV_W'(1);
         level_q <= level_in;
      end
   end

   assign tick      = (div_q == '0);
   assign rise      = level_in & ~level_q;
   assign fall      = ~level_in & level_q;
   assign pressed   = level_q;
   assign cnt_inc   = cnt + CNT_W'(1);
   assign long_hit  = (cnt_inc == CNT_W'(LONG_PRESS_TICKS));
   assign delay_hit = (cnt_inc == CNT_W'(REPEAT_DELAY_TICKS));
   assign intv_hit  = (cnt_inc == CNT_W'(REPEAT_INTERVAL_TICKS));

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Release is checked before tick expiry so a coincident fall wins.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         S_IDLE: begin
            if (rise) begin
               state_nxt = S_PRESSED;
               cnt_nxt   = '0;
            end
         end
         S_PRESSED: begin
            if (fall) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else if (tick) begin
               if (long_hit) begin
                  state_nxt = S_HELD;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
         end
         S_HELD: begin
            if (fall) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else if (tick) begin
               if (delay_hit) begin
                  state_nxt = S_REPEATING;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
         end
         S_REPEATING: begin
            if (fall) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else if (tick) begin
               cnt_nxt = intv_hit ? '0 : cnt_inc;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      ev_new  = 1'b0;
      ev_code = EV_PRESS;
      unique case (state)
         S_IDLE: begin
            if (rise) begin
               ev_new  = 1'b1;
               ev_code = EV_PRESS;
            end
         end
         S_PRESSED: begin
            if (fall) begin
               ev_new  = 1'b1;
               ev_code = EV_REL_SHORT;
            end else if (tick && long_hit) begin
               ev_new  = 1'b1;
               ev_code = EV_LONG;
            end
         end
         S_HELD: begin
            if (fall) begin
               ev_new  = 1'b1;
               ev_code = EV_REL_LONG;
            end else if (tick && delay_hit) begin
               ev_new  = 1'b1;
               ev_code = EV_REPEAT;
            end
         end
         S_REPEATING: begin
            if (fall) begin
               ev_new  = 1'b1;
               ev_code = EV_REL_LONG;
            end else if (tick && intv_hit) begin
               ev_new  = 1'b1;
               ev_code = EV_REPEAT;
            end
         end
         default: begin
            ev_new  = 1'b0;
            ev_code = EV_PRESS;
         end
      endcase
   end

`ifdef BUTTON_EVENT_FIFO_EN
   logic [2:0] mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;
   logic       full;
   logic       pop;
   logic       push;
   logic       ovf_q;

   assign full = (count == 3'd4);
   assign pop  = (count != 3'd0) & event_ready;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign push = ev_new & (~full | pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= ev_code;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         count <= count + {2'b00, push} - {2'b00, pop};
         ovf_q <= ev_new & full & ~pop;
      end
   end

   assign event_valid    = (count != 3'd0);
   assign event_code     = mem[rd_ptr];
   assign event_overflow = ovf_q;
`else
   logic       valid_q;
   logic [2:0] code_q;
   logic       ovf_q;
   logic       load;

   // Loading over an accepted event keeps valid high with no gap.
   assign load = ev_new & (~valid_q | event_ready);

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= 1'b0;
         code_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (load) begin
            valid_q <= 1'b1;
            code_q  <= ev_code;
         end else if (valid_q && event_ready) begin
            valid_q <= 1'b0;
         end
         ovf_q <= ev_new & valid_q & ~event_ready;
      end
   end

   assign event_valid    = valid_q;
   assign event_code     = code_q;
   assign event_overflow = ovf_q;
`endif

endmodule
